// File: rtl/johnson_decoder.sv
// Johnson-code decoder and step monitor: index/one-hot decode, legality and +1 step tracking.
// Latency 1 cycle from code_valid; no backpressure, every valid sample is consumed.
// Optional JOHNSON_DIR_EN: accept -1 steps as valid and report direction on dir_out.
module johnson_decoder #(
  parameter int N     = 4,
  parameter int IDX_W = 3,
  parameter int ERR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       code_in,
  input  logic               code_valid,
  input  logic               clear_err,
  output logic               out_valid,
  output logic [IDX_W-1:0]   idx_out,
  output logic [2*N-1:0]     onehot_out,
  output logic               legal,
  output logic               step_ok,
  output logic               locked,
  output logic               err_sticky,
`ifdef JOHNSON_DIR_EN
  output logic               dir_out,
`endif
  output logic [ERR_W-1:0]   err_count
);

  typedef enum logic {SYNC = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [IDX_W:0]   TWO_N = (IDX_W+1)'(2*N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(2*N-1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   prev_q, prev_d;
  logic [IDX_W-1:0]   pop;
  logic [N-1:0]       lo_pat, hi_pat;
  logic               code_ok;
  logic [IDX_W-1:0]   code_idx;
  logic [IDX_W-1:0]   succ, pred;
  logic               err_evt;

  logic               out_valid_d, legal_d, step_ok_d, sticky_d;
  logic [IDX_W-1:0]   idx_d;
  logic [2*N-1:0]     onehot_d;
  logic [ERR_W-1:0]   count_d;
`ifdef JOHNSON_DIR_EN
  logic               dir_q, dir_d;
`endif

  // A legal code is fully determined by its popcount and MSB, so rebuild the
  // expected pattern and compare rather than enumerating all 2N codes.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + IDX_W'(code_in[i]);
    for (int i = 0; i < N; i++) begin
      lo_pat[i] = (i < int'(pop));
      hi_pat[i] = (i >= N - int'(pop));
    end
    code_ok  = code_in[N-1] ? (code_in == hi_pat) : (code_in == lo_pat);
    code_idx = code_in[N-1] ? IDX_W'(TWO_N - {1'b0, pop}) : pop;
  end

  assign succ = (prev_q == LAST) ? '0 : prev_q + 1'b1;
  assign pred = (prev_q == '0) ? LAST : prev_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    out_valid_d = 1'b0;
    idx_d       = idx_out;
    onehot_d    = onehot_out;
    legal_d     = legal;
    step_ok_d   = step_ok;
    sticky_d    = err_sticky;
    count_d     = err_count;
    err_evt     = 1'b0;
`ifdef JOHNSON_DIR_EN
    dir_d       = dir_q;
`endif
    if (code_valid) begin
      out_valid_d = 1'b1;
      legal_d     = code_ok;
      step_ok_d   = 1'b0;
      if (code_ok) begin
        idx_d              = code_idx;
        onehot_d           = '0;
        onehot_d[code_idx] = 1'b1;
        if (state_q == SYNC) begin
          state_d = LOCK;
          prev_d  = code_idx;
        end else if (code_idx == succ) begin
          step_ok_d = 1'b1;
          prev_d    = code_idx;
`ifdef JOHNSON_DIR_EN
          dir_d     = 1'b1;
`endif
        end else if (code_idx == prev_q) begin
          step_ok_d = 1'b0;
`ifdef JOHNSON_DIR_EN
        end else if (code_idx == pred) begin
          step_ok_d = 1'b1;
          prev_d    = code_idx;
          dir_d     = 1'b0;
`endif
        end else begin
          err_evt = 1'b1;
          prev_d  = code_idx;
        end
      end else begin
        onehot_d = '0;
        err_evt  = 1'b1;
        state_d  = SYNC;
      end
    end
    // A simultaneous error outranks clear_err so the new fault is never lost.
    if (err_evt) begin
      sticky_d = 1'b1;
      if (clear_err)        count_d = ERR_W'(1);
      else if (!(&err_count)) count_d = err_count + 1'b1;
    end else if (clear_err) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      prev_q     <= '0;
      out_valid  <= 1'b0;
      idx_out    <= '0;
      onehot_out <= '0;
      legal      <= 1'b0;
      step_ok    <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
`ifdef JOHNSON_DIR_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      out_valid  <= out_valid_d;
      idx_out    <= idx_d;
      onehot_out <= onehot_d;
      legal      <= legal_d;
      step_ok    <= step_ok_d;
      err_sticky <= sticky_d;
      err_count  <= count_d;
`ifdef JOHNSON_DIR_EN
      dir_q      <= dir_d;
`endif
    end
  end

  assign locked = (state_q == LOCK);
`ifdef JOHNSON_DIR_EN
  assign dir_out = dir_q;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (N=4): table-driven reference model, directed + random stimulus.
module tb_johnson_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] code_in = 4'b0000;
  logic       code_valid = 1'b0;
  logic       clear_err = 1'b0;
  logic       out_valid;
  logic [2:0] idx_out;
  logic [7:0] onehot_out;
  logic       legal, step_ok, locked, err_sticky;
  logic [7:0] err_count;
  logic       dir_act;

`ifdef JOHNSON_DIR_EN
  localparam bit DIR_EN = 1'b1;
  logic dir_out;
  assign dir_act = dir_out;
`else
  localparam bit DIR_EN = 1'b0;
  assign dir_act = 1'b0;
`endif

  johnson_decoder #(.N(4), .IDX_W(3), .ERR_W(8)) dut (
    .clock(clock), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .clear_err(clear_err), .out_valid(out_valid), .idx_out(idx_out),
    .onehot_out(onehot_out), .legal(legal), .step_ok(step_ok), .locked(locked),
    .err_sticky(err_sticky),
`ifdef JOHNSON_DIR_EN
    .dir_out(dir_out),
`endif
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] oh;
    logic       legal;
    logic       step;
    logic       locked;
    logic       sticky;
    logic [7:0] cnt;
    logic       dir;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  // Reference model state
  bit synced;
  int prev, last_idx, cnt;
  bit sticky, dir;

  function automatic exp_t actual();
    exp_t a;
    a = '{idx: idx_out, oh: onehot_out, legal: legal, step: step_ok, locked: locked,
          sticky: err_sticky, cnt: err_count, dir: dir_act};
    return a;
  endfunction

  task automatic model_reset();
    synced = 0; prev = 0; last_idx = 0; cnt = 0; sticky = 0; dir = 0;
  endtask

  task automatic apply(input logic [3:0] c, input logic v, input logic clr);
    int   found;
    bit   err;
    bit   step;
    exp_t e;
    @(negedge clock);
    code_in = c; code_valid = v; clear_err = clr;
    found = -1;
    for (int i = 0; i < 8; i++) if (codes[i] == c) found = i;
    err = 0; step = 0;
    if (v) begin
      if (found >= 0) begin
        if (!synced) begin
          synced = 1; prev = found;
        end else begin
          int d;
          d = (found - prev + 8) % 8;
          if (d == 1) begin
            step = 1; prev = found; if (DIR_EN) dir = 1;
          end else if (d == 0) begin
            step = 0;
          end else if (DIR_EN && d == 7) begin
            step = 1; prev = found; dir = 0;
          end else begin
            err = 1; prev = found;
          end
        end
        last_idx = found;
      end else begin
        err = 1; synced = 0;
      end
    end
    if (err) begin
      sticky = 1;
      cnt = clr ? 1 : (cnt < 255 ? cnt + 1 : 255);
    end else if (clr) begin
      sticky = 0; cnt = 0;
    end
    if (v) begin
      e.idx    = 3'(last_idx);
      e.oh     = (found >= 0) ? 8'(1 << found) : 8'h00;
      e.legal  = (found >= 0);
      e.step   = step;
      e.locked = synced;
      e.sticky = sticky;
      e.cnt    = 8'(cnt);
      e.dir    = dir;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    code_valid = 0; clear_err = 0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (actual() !== exp_t'(0) || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %h out_valid=%b, want all zero", actual(), out_valid);
    end
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: one-cycle latency means every queued entry must appear at the next edge.
  always @(posedge clock) begin
    exp_t e, a;
    #1;
    if (!reset) begin
      if (out_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out_valid: got out_valid=1, want 0 (nothing issued)");
        end else begin
          e = q.pop_front();
          a = actual();
          if (a !== e) begin
            miscompares++;
            $display("FAIL sample t=%0t: got idx=%0d oh=%b legal=%b step=%b lock=%b stk=%b cnt=%0d dir=%b; want idx=%0d oh=%b legal=%b step=%b lock=%b stk=%b cnt=%0d dir=%b",
                     $time, a.idx, a.oh, a.legal, a.step, a.locked, a.sticky, a.cnt, a.dir,
                     e.idx, e.oh, e.legal, e.step, e.locked, e.sticky, e.cnt, e.dir);
          end
        end
      end else if (q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_out_valid t=%0t: got out_valid=0, want 1", $time);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    // Full sequence with wrap 7->0
    for (int i = 0; i < 8; i++) apply(codes[i], 1'b1, 1'b0);
    apply(codes[0], 1'b1, 1'b0);
    // Illegal code while locked at 3, then resync
    apply(4'b0001, 1'b1, 1'b0);
    apply(4'b0011, 1'b1, 1'b0);
    apply(4'b0111, 1'b1, 1'b0);
    apply(4'b0101, 1'b1, 1'b0);
    apply(4'b1111, 1'b1, 1'b0);
    // Stall then advance
    do_reset();
    apply(4'b0011, 1'b1, 1'b0);
    apply(4'b0011, 1'b1, 1'b0);
    apply(4'b0011, 1'b1, 1'b0);
    apply(4'b0111, 1'b1, 1'b0);
    // Skip error then good step
    do_reset();
    apply(4'b0001, 1'b1, 1'b0);
    apply(4'b1111, 1'b1, 1'b0);
    apply(4'b1110, 1'b1, 1'b0);
    // Saturation, clear-vs-error priority, clear alone
    for (int i = 0; i < 260; i++) apply(4'b0101, 1'b1, 1'b0);
    apply(4'b0101, 1'b1, 1'b1);
    apply(4'b0000, 1'b0, 1'b1);
    apply(4'b0000, 1'b1, 1'b0);
    apply(4'b1010, 1'b0, 1'b0);
    apply(4'b0001, 1'b1, 1'b0);
    // Reverse step
    do_reset();
    apply(4'b1110, 1'b1, 1'b0);
    apply(4'b1111, 1'b1, 1'b0);
    apply(4'b0111, 1'b1, 1'b0);
    idle(2);
    // Randomized stream with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      int         sel;
      logic [3:0] c;
      if (n == 300) begin
        idle(2);
        do_reset();
      end
      sel = $urandom_range(0, 99);
      if (sel < 55)      c = codes[(last_idx + 1) % 8];
      else if (sel < 65) c = codes[last_idx];
      else if (sel < 75) c = codes[(last_idx + 7) % 8];
      else if (sel < 85) c = codes[$urandom_range(0, 7)];
      else               c = 4'($urandom_range(0, 15));
      apply(c, ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0));
    end
    idle(3);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
